// File: rtl/dot4x_reset_sequencer_pkg.sv
// Shared types and constants for the dot4x reset sequencer.
// Holds the sequencer state encoding and the dot/phi timing constants.
// Imported by dot4x_reset_sequencer; the synchronizer needs nothing from here.
package dot4x_reset_sequencer_pkg;

  localparam int PHASE_W             = 5;
  localparam int DOT4X_PER_DOT       = 4;
  localparam int DOTS_PER_PHI        = 8;
  localparam int HOLD_CYCLES_DEFAULT = 16;

  // One phi period in clk_dot4x cycles (32).
  localparam int PHI_PERIOD = DOT4X_PER_DOT * DOTS_PER_PHI;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

endpackage

// File: rtl/dot4x_reset_sequencer_sync.sv
// dot4x_sync: multi-flop synchronizer bringing an asynchronous level into clk.
// Latency STAGES clk edges; no backpressure (free-running level path).
// Ports: clk, rst (async active-high, clears chain to 0), d (async in), q (synchronized out).
module dot4x_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dot4x_reset_sequencer.sv
// dot4x_reset_sequencer: releases the dot4x-domain reset once PLL lock has been
// stable for HOLD_CYCLES, then generates dot_en / clk_phi / phi_start timing.
// Latency SYNC_STAGES+HOLD_CYCLES+1 edges from locked=1 to reset release; no backpressure.
// Ports: clk_dot4x, reset (async active-high), locked (async) in; rst_dot4x, dot_en,
// clk_phi, phi_start, phase[4:0], lock_loss_count[7:0] out.
// Optional macro LOCK_LOSS_COUNT_EN: enables the saturating lock-loss counter;
// when undefined lock_loss_count is tied to zero.
module dot4x_reset_sequencer
  import dot4x_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic               clk_dot4x,
  input  logic               reset,
  input  logic               locked,
  output logic               rst_dot4x,
  output logic               dot_en,
  output logic               clk_phi,
  output logic               phi_start,
  output logic [PHASE_W-1:0] phase,
  output logic [7:0]         lock_loss_count
);

  localparam logic [7:0]         HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHI_PERIOD - 1);
  localparam logic [1:0]         DOT_LAST   = 2'(DOT4X_PER_DOT - 1);

  logic               locked_s;
  state_t             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               rst_q;
  logic               run;

  dot4x_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk_dot4x),
    .rst (reset),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    phase_d = '0;
    case (state_q)
      WAIT_LOCK: begin
        hold_d = '0;
        if (locked_s) state_d = HOLD;
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 8'd1;
          if (hold_q == HOLD_LAST) state_d = RUN;
        end
      end
      RUN: begin
        // phase_d stays 0 on the HOLD->RUN edge, so the first RUN cycle is phase 0.
        if (!locked_s) state_d = WAIT_LOCK;
        else           phase_d = phase_q + 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_dot4x or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      hold_q  <= '0;
      phase_q <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      // Tracks the next state so reset flips on the same edge the FSM changes.
      rst_q   <= (state_d != RUN);
    end
  end

  assign run       = (state_q == RUN);
  assign rst_dot4x = rst_q;
  assign phase     = phase_q;
  assign dot_en    = run && (phase_q[1:0] == DOT_LAST);
  assign clk_phi   = run && phase_q[PHASE_W-1];
  assign phi_start = run && (phase_q == PHASE_LAST);

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk_dot4x or posedge reset) begin
    if (reset) begin
      loss_q <= '0;
    end else if (run && (state_d == WAIT_LOCK) && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_dot4x_reset_sequencer.sv
// Testbench for dot4x_reset_sequencer: directed scenarios plus random lock
// toggling, every edge compared against a behavioural model.
// The model tracks locked through a delay queue and counts consecutive lock samples.
module tb_dot4x_reset_sequencer;

  localparam int S   = 2;
  localparam int H   = 16;
  localparam int LAT = S + H + 1;
`ifdef LOCK_LOSS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk_dot4x = 1'b0;
  logic       reset     = 1'b0;
  logic       locked    = 1'b0;
  logic       rst_dot4x, dot_en, clk_phi, phi_start;
  logic [4:0] phase;
  logic [7:0] lock_loss_count;

  dot4x_reset_sequencer #(
    .SYNC_STAGES (S),
    .HOLD_CYCLES (H)
  ) dut (
    .clk_dot4x       (clk_dot4x),
    .reset           (reset),
    .locked          (locked),
    .rst_dot4x       (rst_dot4x),
    .dot_en          (dot_en),
    .clk_phi         (clk_phi),
    .phi_start       (phi_start),
    .phase           (phase),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: the FSM sees locked as sampled S edges earlier; the
  // design runs once it has seen H+1 consecutive lock samples.
  int m_q[$];
  int m_ones = 0;
  int m_loss = 0;

  function automatic void m_reset();
    m_q.delete();
    for (int i = 0; i < S; i++) m_q.push_back(0);
    m_ones = 0;
    m_loss = 0;
  endfunction

  function automatic bit m_run();
    return m_ones >= H + 1;
  endfunction

  function automatic int m_phase();
    return m_run() ? (m_ones - (H + 1)) % 32 : 0;
  endfunction

  function automatic void m_edge(input logic l);
    int fin;
    fin = m_q.pop_front();
    m_q.push_back(int'(l));
    if (fin != 0) begin
      m_ones++;
    end else begin
      if (m_run() && m_loss < 255) m_loss++;
      m_ones = 0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int p;
    p = m_phase();
    check({tag, ".rst_dot4x"}, 32'(rst_dot4x), 32'(!m_run()));
    check({tag, ".phase"},     32'(phase), 32'(p));
    check({tag, ".dot_en"},    32'(dot_en), 32'(m_run() && (p % 4 == 3)));
    check({tag, ".clk_phi"},   32'(clk_phi), 32'(m_run() && (p >= 16)));
    check({tag, ".phi_start"}, 32'(phi_start), 32'(m_run() && (p == 31)));
    check({tag, ".loss"},      32'(lock_loss_count), CNT_EN ? 32'(m_loss) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk_dot4x);
    m_edge(locked);
    #1;
    check_all("edge");
  endtask

  // Counts edges, starting with the next one, until rst_dot4x drops.
  task automatic wait_release(output int n);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (rst_dot4x === 1'b0) break;
    end
  endtask

  initial begin
    int n, dot_cnt, phi_cnt, tog_cnt;
    logic prev_phi;

    m_reset();
    #1 reset = 1'b1;
    #1 check_all("reset_async");
    repeat (3) @(posedge clk_dot4x);
    #1 check_all("reset_held");
    @(negedge clk_dot4x);
    reset = 1'b0;

    // Release latency from the first lock sample.
    locked = 1'b1;
    wait_release(n);
    check("latency_first", 32'(n), 32'(LAT));
    check("phase_at_release", 32'(phase), 32'd0);
    check("loss_at_release", 32'(lock_loss_count), 32'd0);

    // Dot / phi timing over two phi periods.
    dot_cnt = 0; phi_cnt = 0; tog_cnt = 0; prev_phi = clk_phi;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (dot_en) begin
        dot_cnt++;
        check("dot_en_phase", 32'(phase[1:0]), 32'd3);
      end
      if (phi_start) phi_cnt++;
      if (clk_phi != prev_phi) tog_cnt++;
      prev_phi = clk_phi;
    end
    check("dot_en_count", 32'(dot_cnt), 32'd16);
    check("phi_start_count", 32'(phi_cnt), 32'd2);
    check("clk_phi_toggles", 32'(tog_cnt), 32'd4);

    // Lock loss at phase 10.
    n = 0;
    while (!(m_run() && m_phase() == 10) && n < 40) begin tick(); n++; end
    check("reach_phase10", 32'(phase), 32'd10);
    locked = 1'b0;
    repeat (2) tick();
    check("loss_still_run", 32'(rst_dot4x), 32'd0);
    tick();
    check("loss_rst", 32'(rst_dot4x), 32'd1);
    check("loss_phase", 32'(phase), 32'd0);
    check("loss_dot_en", 32'(dot_en), 32'd0);
    check("loss_clk_phi", 32'(clk_phi), 32'd0);
    check("loss_count1", 32'(lock_loss_count), CNT_EN ? 32'd1 : 32'd0);

    // Lock drop during HOLD when the hold counter is 8.
    repeat (4) tick();
    locked = 1'b1;
    n = 0;
    while (m_ones != 9 && n < 40) begin tick(); n++; end
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    wait_release(n);
    check("latency_relock", 32'(n), 32'(LAT));

    // Asynchronous reset mid-RUN at phase 20.
    n = 0;
    while (!(m_run() && m_phase() == 20) && n < 40) begin tick(); n++; end
    check("reach_phase20", 32'(phase), 32'd20);
    #2 reset = 1'b1;
    m_reset();
    #1 check_all("mid_run_reset");
    #1 reset = 1'b0;
    wait_release(n);
    check("latency_after_reset", 32'(n), 32'(LAT));

    // Random lock toggling, including short dropouts.
    for (int seg = 0; seg < 40; seg++) begin
      locked = ~locked;
      repeat ($urandom_range(1, 30)) tick();
    end

    // Many lock-loss/relock cycles for counter saturation.
    locked = 1'b0;
    repeat (S + 2) tick();
    for (int k = 0; k < 300; k++) begin
      locked = 1'b1;
      repeat (LAT + 1) tick();
      locked = 1'b0;
      repeat (S + 2) tick();
    end
    check("loss_saturated", 32'(lock_loss_count), CNT_EN ? 32'd255 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dot4x_reset_sequencer.md
DOT4X_RESET_SEQUENCER -- requirements
Module: dot4x_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on locked (legal 2..4).
REQ-002 Parameter HOLD_CYCLES, default 16, clk_dot4x cycles locked must stay stable before reset release (legal 2..255).
REQ-003 clk_dot4x  input  1  sole clock, PLL-generated dot4x clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 locked  input  1  PLL lock status, asynchronous to clk_dot4x.
REQ-006 rst_dot4x  output  1  active-high reset for the downstream dot4x domain, registered.
REQ-007 dot_en  output  1  single-cycle enable, one per 4 clk_dot4x cycles (pixel-dot rate).
REQ-008 clk_phi  output  1  phi level: 16 cycles low then 16 cycles high (8 dots per phi).
REQ-009 phi_start  output  1  single-cycle pulse in the last cycle of each phi period.
REQ-010 phase  output  5  current dot4x phase within the phi period, 0..31.
REQ-011 lock_loss_count  output  8  saturating count of lock losses while running.

Function
REQ-012 locked passes through a SYNC_STAGES-deep flop chain; only the synchronized value (locked_s) is used.
REQ-013 FSM states: WAIT_LOCK, HOLD, RUN.
REQ-014 WAIT_LOCK: locked_s=1 -> HOLD with hold counter cleared to 0; otherwise remain.
REQ-015 HOLD: counter increments each cycle; locked_s=0 -> WAIT_LOCK (counter cleared); counter==HOLD_CYCLES-1 with locked_s=1 -> RUN.
REQ-016 RUN: locked_s=0 -> WAIT_LOCK; otherwise remain.
REQ-017 rst_dot4x is a flop updated on the same edge as the state: 0 exactly while state is RUN, 1 otherwise.
REQ-018 Latency from the first edge sampling locked=1 to rst_dot4x=0: SYNC_STAGES+HOLD_CYCLES+1 edges (19 at defaults).
REQ-019 phase is 0 in the first RUN cycle and increments by 1 per cycle mod 32; held at 0 outside RUN.
REQ-020 dot_en=1 iff state is RUN and phase[1:0]==3; clk_phi=phase[4] in RUN, 0 otherwise; phi_start=1 iff state is RUN and phase==31.
REQ-021 On RUN->WAIT_LOCK, all of dot_en, phi_start, clk_phi and phase are 0 and rst_dot4x is 1 from the transition edge onward.
REQ-022 Lock loss is detected SYNC_STAGES+1 edges after locked falls; glitches shorter than one clk_dot4x period need not be detected.

Reset
REQ-023 reset asynchronously forces: state WAIT_LOCK, synchronizer and hold counter 0, rst_dot4x=1, dot_en=0, clk_phi=0, phi_start=0, phase=0, lock_loss_count=0.
REQ-024 reset asserted mid-RUN takes effect without a clock edge; after release, the sequence restarts from WAIT_LOCK.

Configuration
REQ-025 Macro LOCK_LOSS_COUNT_EN defined: lock_loss_count increments by 1 on each RUN->WAIT_LOCK transition, saturating at 255.
REQ-026 Macro LOCK_LOSS_COUNT_EN undefined: no counter logic; lock_loss_count port still present, tied to 8'd0.

Structure
REQ-027 Shared package holds the state enum, PHASE_W=5, DOT4X_PER_DOT=4, DOTS_PER_PHI=8 and the default HOLD_CYCLES constant.
REQ-028 The locked synchronizer is a separate sub-module, dot4x_sync (parameterized depth, reset value 0).

Verification
REQ-029 Defaults; reset released; locked=1 held -> rst_dot4x falls on edge 19; phase=0 on that cycle; lock_loss_count=0.
REQ-030 In RUN over 64 cycles -> dot_en at phase 3,7,...,31 (16 pulses), phi_start at phase 31 (2 pulses), clk_phi toggles on each 0/16 boundary.
REQ-031 locked drops when hold counter=8, returns 3 cycles later -> rst_dot4x stays 1; release occurs 19 edges after the edge that re-samples locked=1.
REQ-032 locked drops at phase 10 in RUN -> 3 edges later rst_dot4x=1, phase=0, dot_en=0, clk_phi=0; lock_loss_count=1 with macro, 0 without.
REQ-033 reset pulsed asynchronously mid-RUN at phase 20 -> all outputs at REQ-023 values before the next clk_dot4x edge; normal restart after release.
REQ-034 With macro, 300 lock-loss/relock cycles -> lock_loss_count saturates at 255 and does not wrap.
